// File: rtl/addr_div_unit.sv
// Iterative unsigned restoring divider: BITS_PER_CYCLE quotient bits per clock, MSB first.
// Start/busy/done handshake; fixed latency of WIDTH/BITS_PER_CYCLE clocks, starts ignored while busy.
module addr_div_unit #(
    parameter int WIDTH          = 24,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_aj,
    input  logic [WIDTH-1:0] i_ak,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_zero
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_acc_q, quo_acc_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dz_flag_q, dz_flag_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   r_step;
    logic [WIDTH-1:0] d_step;
    logic [WIDTH-1:0] q_step;

    // Partial remainder stays below the divisor between steps, so one extra bit holds the shifted value.
    always_comb begin
        r_step = rem_q;
        d_step = dvd_q;
        q_step = quo_acc_q;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            r_step = {r_step[WIDTH-1:0], d_step[WIDTH-1]};
            d_step = {d_step[WIDTH-2:0], 1'b0};
            if (r_step >= {1'b0, dvs_q}) begin
                r_step = r_step - {1'b0, dvs_q};
                q_step = {q_step[WIDTH-2:0], 1'b1};
            end else begin
                q_step = {q_step[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_acc_d = quo_acc_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        dz_flag_d = dz_flag_q;
        quo_d     = quo_q;
        rem_out_d = rem_out_q;
        dz_d      = dz_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    dvd_d     = i_aj;
                    dvs_d     = i_ak;
                    dz_flag_d = (i_ak == '0);
                    rem_d     = '0;
                    quo_acc_d = '0;
                    cnt_d     = CW'(N);
                    state_d   = CALC;
                end
            end
            CALC: begin
                rem_d     = r_step;
                dvd_d     = d_step;
                quo_acc_d = q_step;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quo_d     = q_step;
                    rem_out_d = r_step[WIDTH-1:0];
                    dz_d      = dz_flag_q;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            quo_acc_q <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            dz_flag_q <= 1'b0;
            quo_q     <= '0;
            rem_out_q <= '0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            quo_acc_q <= quo_acc_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            dz_flag_q <= dz_flag_d;
            quo_q     <= quo_d;
            rem_out_q <= rem_out_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
        end
    end

    assign o_busy      = (state_q == CALC);
    assign o_done      = done_q;
    assign o_quotient  = quo_q;
    assign o_remainder = rem_out_q;
    assign o_div_zero  = dz_q;

endmodule

// File: tb/tb_addr_div_unit.sv
// Directed bench for addr_div_unit: reset, timing, boundaries, divide-by-zero, request handling.
module tb_addr_div_unit;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [23:0] i_aj;
    logic [23:0] i_ak;
    logic        o_busy;
    logic        o_done;
    logic [23:0] o_quotient;
    logic [23:0] o_remainder;
    logic        o_div_zero;

    int checks;
    int errors;

    addr_div_unit #(.WIDTH(24), .BITS_PER_CYCLE(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_aj       (i_aj),
        .i_ak       (i_ak),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_quotient (o_quotient),
        .o_remainder(o_remainder),
        .o_div_zero (o_div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
        chk({tag, "_q"},    {8'd0, o_quotient}, 32'd0);
        chk({tag, "_r"},    {8'd0, o_remainder}, 32'd0);
        chk({tag, "_dz"},   {31'd0, o_div_zero}, 32'd0);
    endtask

    // Start at e0, expect busy after e0, no done e1..e11, results and done after e12.
    task automatic run_div(input string tag, input logic [23:0] aj, input logic [23:0] ak,
                           input logic [23:0] eq, input logic [23:0] er, input logic edz);
        i_start = 1'b1;
        i_aj    = aj;
        i_ak    = ak;
        tick();
        i_start = 1'b0;
        chk({tag, "_busy0"}, {31'd0, o_busy}, 32'd1);
        for (int k = 1; k < 12; k++) begin
            tick();
            chk({tag, "_early_done"}, {31'd0, o_done}, 32'd0);
        end
        tick();
        chk({tag, "_done"}, {31'd0, o_done}, 32'd1);
        chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_q"},    {8'd0, o_quotient}, {8'd0, eq});
        chk({tag, "_r"},    {8'd0, o_remainder}, {8'd0, er});
        chk({tag, "_dz"},   {31'd0, o_div_zero}, {31'd0, edz});
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        i_start = 1'b1;
        i_aj    = 24'($urandom);
        i_ak    = 24'($urandom);

        // Reset held with start asserted
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_zero_outs("rst");
            i_aj = 24'($urandom);
            i_ak = 24'($urandom);
        end
        rst     = 1'b0;
        i_start = 1'b0;
        tick();
        chk_zero_outs("rst_rel");

        // Basic timing
        run_div("basic", 24'd1000, 24'd7, 24'd142, 24'd6, 1'b0);
        tick();
        chk("basic_done_e13", {31'd0, o_done}, 32'd0);
        for (int k = 0; k < 7; k++) tick();
        chk("basic_q_e20", {8'd0, o_quotient}, 32'd142);
        chk("basic_r_e20", {8'd0, o_remainder}, 32'd6);

        // Boundaries
        run_div("max_by_1", 24'hFFFFFF, 24'd1, 24'hFFFFFF, 24'd0, 1'b0);
        run_div("small",    24'd5, 24'd9, 24'd0, 24'd5, 1'b0);
        run_div("max_max",  24'hFFFFFF, 24'hFFFFFF, 24'd1, 24'd0, 1'b0);
        run_div("zero_dvd", 24'd0, 24'd3, 24'd0, 24'd0, 1'b0);

        // Divide by zero
        run_div("dz",       24'h123456, 24'd0, 24'hFFFFFF, 24'h123456, 1'b1);
        run_div("after_dz", 24'd10, 24'd2, 24'd5, 24'd0, 1'b0);

        // Start while busy ignored; start during done accepted
        i_start = 1'b1;
        i_aj    = 24'd100;
        i_ak    = 24'd3;
        tick();
        i_start = 1'b0;
        for (int k = 1; k < 12; k++) begin
            if (k == 5) begin
                i_start = 1'b1;
                i_aj    = 24'd50;
                i_ak    = 24'd5;
            end
            tick();
            if (k == 5) i_start = 1'b0;
            chk("req_early_done", {31'd0, o_done}, 32'd0);
            chk("req_busy", {31'd0, o_busy}, 32'd1);
        end
        // the loop ends after e11 with i_start low; the e5 pulse covered edge e5
        tick();
        chk("req_done", {31'd0, o_done}, 32'd1);
        chk("req_q", {8'd0, o_quotient}, 32'd33);
        chk("req_r", {8'd0, o_remainder}, 32'd1);
        i_start = 1'b1;
        i_aj    = 24'd81;
        i_ak    = 24'd9;
        tick();
        i_start = 1'b0;
        chk("b2b_busy", {31'd0, o_busy}, 32'd1);
        chk("b2b_done_clr", {31'd0, o_done}, 32'd0);
        chk("b2b_q_hold", {8'd0, o_quotient}, 32'd33);
        for (int k = 14; k < 25; k++) begin
            tick();
            chk("b2b_early_done", {31'd0, o_done}, 32'd0);
        end
        tick();
        chk("b2b_done", {31'd0, o_done}, 32'd1);
        chk("b2b_q", {8'd0, o_quotient}, 32'd9);
        chk("b2b_r", {8'd0, o_remainder}, 32'd0);

        // Reset mid-operation
        i_start = 1'b1;
        i_aj    = 24'd1000;
        i_ak    = 24'd7;
        tick();
        i_start = 1'b0;
        for (int k = 1; k < 6; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero_outs("midrst");
        for (int k = 0; k < 14; k++) begin
            tick();
            chk("midrst_no_done", {31'd0, o_done}, 32'd0);
        end
        run_div("post_rst", 24'd81, 24'd9, 24'd9, 24'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
